// File: rtl/spi_ram_pkg.sv
// Shared command codes, FSM state encoding and requester IDs for the SPI/host RAM arbiter.
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StAccess = 2'b01,
        StRdWait = 2'b10,
        StResp   = 2'b11
    } state_e;

    // Bit positions in the request / grant vectors.
    localparam logic REQ_SPI  = 1'b0;
    localparam logic REQ_HOST = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: one-hot grant, pointer records the last side granted.
module rr_arbiter_2
    import spi_ram_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] gnt_o
);

    logic last_host_q;

    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o = last_host_q ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
    end

    // Reset as if the host was served last so the SPI side wins the first contest.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_host_q <= 1'b1;
        end else if (update_i && (|req_i)) begin
            last_host_q <= gnt_o[REQ_HOST];
        end
    end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares a single-port RAM between decoded SPI commands and a host port.
// Optional feature: define SPI_RAM_AUTO_INC_EN to post-increment SPI addresses on 01/11.
module spi_ram_arbiter
    import spi_ram_pkg::*;
#(
    parameter int unsigned MemDepth = 256,
    parameter int unsigned AddrSize = $clog2(MemDepth)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [AddrSize+1:0] spi_rx_data_i,
    input  logic                spi_rx_valid_i,
    output logic [AddrSize-1:0] spi_tx_data_o,
    output logic                spi_tx_valid_o,
    output logic                spi_ovf_o,
    input  logic                host_req_i,
    input  logic                host_we_i,
    input  logic [AddrSize-1:0] host_addr_i,
    input  logic [AddrSize-1:0] host_wdata_i,
    output logic                host_gnt_o,
    output logic [AddrSize-1:0] host_rdata_o,
    output logic                host_rvalid_o,
    output logic                ram_en_o,
    output logic                ram_we_o,
    output logic [AddrSize-1:0] ram_addr_o,
    output logic [AddrSize-1:0] ram_wdata_o,
    input  logic [AddrSize-1:0] ram_rdata_i
);

    state_e              state_q;
    logic                winner_host_q;

    logic [AddrSize-1:0] wr_addr_q;
    logic [AddrSize-1:0] rd_addr_q;
    logic                pend_valid_q;
    logic                pend_we_q;
    logic [AddrSize-1:0] pend_addr_q;
    logic [AddrSize-1:0] pend_wdata_q;
    logic                spi_ovf_q;

    logic                ram_en_q;
    logic                ram_we_q;
    logic [AddrSize-1:0] ram_addr_q;
    logic [AddrSize-1:0] ram_wdata_q;
    logic                host_gnt_q;
    logic [AddrSize-1:0] host_rdata_q;
    logic                host_rvalid_q;
    logic [AddrSize-1:0] spi_tx_data_q;
    logic                spi_tx_valid_q;

    logic [1:0]          cmd;
    logic [AddrSize-1:0] payload;
    logic                ram_cmd;
    logic                pend_drop;
    logic [1:0]          arb_req;
    logic [1:0]          arb_gnt;
    logic                arb_update;
    logic                spi_take;

    assign cmd     = spi_rx_data_i[AddrSize+1:AddrSize];
    assign payload = spi_rx_data_i[AddrSize-1:0];

    // cmd[0] set means 01/11: a word that needs the pending slot.
    assign ram_cmd    = spi_rx_valid_i & cmd[0];
    assign pend_drop  = ram_cmd & pend_valid_q;
    assign arb_req    = {host_req_i, pend_valid_q};
    assign arb_update = (state_q == StIdle);
    assign spi_take   = arb_update & arb_gnt[REQ_SPI];

    rr_arbiter_2 u_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (arb_req),
        .update_i (arb_update),
        .gnt_o    (arb_gnt)
    );

    // The slot empties on the grant edge, so it is already free during ACCESS.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_we_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
            spi_ovf_q    <= 1'b0;
        end else begin
            if (spi_take) begin
                pend_valid_q <= 1'b0;
            end
            if (pend_drop) begin
                spi_ovf_q <= 1'b1;
            end
            if (spi_rx_valid_i) begin
                unique case (cmd)
                    CMD_WR_ADDR: wr_addr_q <= payload;
                    CMD_RD_ADDR: rd_addr_q <= payload;
                    CMD_WR_DATA: begin
                        if (!pend_valid_q) begin
                            pend_valid_q <= 1'b1;
                            pend_we_q    <= 1'b1;
                            pend_addr_q  <= wr_addr_q;
                            pend_wdata_q <= payload;
`ifdef SPI_RAM_AUTO_INC_EN
                            wr_addr_q    <= wr_addr_q + AddrSize'(1);
`endif
                        end
                    end
                    CMD_RD_DATA: begin
                        if (!pend_valid_q) begin
                            pend_valid_q <= 1'b1;
                            pend_we_q    <= 1'b0;
                            pend_addr_q  <= rd_addr_q;
                            pend_wdata_q <= '0;
`ifdef SPI_RAM_AUTO_INC_EN
                            rd_addr_q    <= rd_addr_q + AddrSize'(1);
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            winner_host_q  <= 1'b0;
            ram_en_q       <= 1'b0;
            ram_we_q       <= 1'b0;
            ram_addr_q     <= '0;
            ram_wdata_q    <= '0;
            host_gnt_q     <= 1'b0;
            host_rdata_q   <= '0;
            host_rvalid_q  <= 1'b0;
            spi_tx_data_q  <= '0;
            spi_tx_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|arb_gnt) begin
                        state_q       <= StAccess;
                        ram_en_q      <= 1'b1;
                        winner_host_q <= arb_gnt[REQ_HOST];
                        if (arb_gnt[REQ_HOST]) begin
                            ram_we_q    <= host_we_i;
                            ram_addr_q  <= host_addr_i;
                            ram_wdata_q <= host_wdata_i;
                            host_gnt_q  <= 1'b1;
                        end else begin
                            ram_we_q    <= pend_we_q;
                            ram_addr_q  <= pend_addr_q;
                            ram_wdata_q <= pend_wdata_q;
                        end
                    end
                end
                StAccess: begin
                    ram_en_q   <= 1'b0;
                    ram_we_q   <= 1'b0;
                    host_gnt_q <= 1'b0;
                    state_q    <= ram_we_q ? StIdle : StRdWait;
                end
                StRdWait: begin
                    if (winner_host_q) begin
                        host_rdata_q  <= ram_rdata_i;
                        host_rvalid_q <= 1'b1;
                    end else begin
                        spi_tx_data_q  <= ram_rdata_i;
                        spi_tx_valid_q <= 1'b1;
                    end
                    state_q <= StResp;
                end
                StResp: begin
                    host_rvalid_q  <= 1'b0;
                    spi_tx_valid_q <= 1'b0;
                    state_q        <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign spi_tx_data_o  = spi_tx_data_q;
    assign spi_tx_valid_o = spi_tx_valid_q;
    assign spi_ovf_o      = spi_ovf_q;
    assign host_gnt_o     = host_gnt_q;
    assign host_rdata_o   = host_rdata_q;
    assign host_rvalid_o  = host_rvalid_q;
    assign ram_en_o       = ram_en_q;
    assign ram_we_o       = ram_we_q;
    assign ram_addr_o     = ram_addr_q;
    assign ram_wdata_o    = ram_wdata_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter with a behavioural single-port RAM attached.
module tb_spi_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] spi_rx_data;
    logic       spi_rx_valid;
    logic [7:0] spi_tx_data;
    logic       spi_tx_valid;
    logic       spi_ovf;
    logic       host_req;
    logic       host_we;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_gnt;
    logic [7:0] host_rdata;
    logic       host_rvalid;
    logic       ram_en;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    spi_ram_arbiter dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .spi_rx_data_i  (spi_rx_data),
        .spi_rx_valid_i (spi_rx_valid),
        .spi_tx_data_o  (spi_tx_data),
        .spi_tx_valid_o (spi_tx_valid),
        .spi_ovf_o      (spi_ovf),
        .host_req_i     (host_req),
        .host_we_i      (host_we),
        .host_addr_i    (host_addr),
        .host_wdata_i   (host_wdata),
        .host_gnt_o     (host_gnt),
        .host_rdata_o   (host_rdata),
        .host_rvalid_o  (host_rvalid),
        .ram_en_o       (ram_en),
        .ram_we_o       (ram_we),
        .ram_addr_o     (ram_addr),
        .ram_wdata_o    (ram_wdata),
        .ram_rdata_i    (ram_rdata)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Word is present for exactly one clock; returns one negedge later.
    task automatic spi_send(input logic [1:0] c, input logic [7:0] p);
        spi_rx_data  = {c, p};
        spi_rx_valid = 1'b1;
        tick();
        spi_rx_valid = 1'b0;
        spi_rx_data  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic any_en;
        int   n;
        rst          = 1'b1;
        spi_rx_data  = '0;
        spi_rx_valid = 1'b0;
        host_req     = 1'b0;
        host_we      = 1'b0;
        host_addr    = '0;
        host_wdata   = '0;

        // 1: reset state
        repeat (5) tick();
        chk("rst_ram_en", 16'(ram_en), 16'h0);
        chk("rst_ram_we", 16'(ram_we), 16'h0);
        chk("rst_ram_addr", 16'(ram_addr), 16'h0);
        chk("rst_ram_wdata", 16'(ram_wdata), 16'h0);
        chk("rst_host_gnt", 16'(host_gnt), 16'h0);
        chk("rst_host_rvalid", 16'(host_rvalid), 16'h0);
        chk("rst_host_rdata", 16'(host_rdata), 16'h0);
        chk("rst_spi_tx_valid", 16'(spi_tx_valid), 16'h0);
        chk("rst_spi_tx_data", 16'(spi_tx_data), 16'h0);
        chk("rst_spi_ovf", 16'(spi_ovf), 16'h0);
        rst = 1'b0;

        // 2: SPI write 0xA5 to 0x7E, then read it back
        spi_send(2'b00, 8'h7E);
        spi_send(2'b01, 8'hA5);
        chk("w_idle_no_en", 16'(ram_en), 16'h0);
        tick();
        chk("w_access_en", 16'(ram_en), 16'h1);
        chk("w_access_we", 16'(ram_we), 16'h1);
        chk("w_access_addr", 16'(ram_addr), 16'h7E);
        chk("w_access_wdata", 16'(ram_wdata), 16'hA5);
        tick();
        chk("w_after_en", 16'(ram_en), 16'h0);
        spi_send(2'b10, 8'h7E);
        spi_send(2'b11, 8'h33);
        tick();
        chk("r_access_en", 16'(ram_en), 16'h1);
        chk("r_access_we", 16'(ram_we), 16'h0);
        chk("r_access_addr", 16'(ram_addr), 16'h7E);
        tick();
        chk("r_rdwait_valid", 16'(spi_tx_valid), 16'h0);
        tick();
        chk("r_resp_valid", 16'(spi_tx_valid), 16'h1);
        chk("r_resp_data", 16'(spi_tx_data), 16'hA5);
        tick();
        chk("r_pulse_end", 16'(spi_tx_valid), 16'h0);

        // 3: SPI and host contend in the same IDLE cycle; SPI is favoured after reset
        do_reset();
        spi_send(2'b01, 8'h11);
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 8'h40;
        host_wdata = 8'h22;
        tick();
        chk("c_spi_first_addr", 16'(ram_addr), 16'h00);
        chk("c_spi_first_wdata", 16'(ram_wdata), 16'h11);
        chk("c_spi_first_gnt", 16'(host_gnt), 16'h0);
        tick();
        chk("c_idle_gap_en", 16'(ram_en), 16'h0);
        tick();
        chk("c_host_gnt", 16'(host_gnt), 16'h1);
        chk("c_host_addr", 16'(ram_addr), 16'h40);
        chk("c_host_wdata", 16'(ram_wdata), 16'h22);
        host_req = 1'b0;
        tick();
        host_req = 1'b1;
        host_we  = 1'b0;
        tick();
        chk("c_hread_gnt", 16'(host_gnt), 16'h1);
        host_req = 1'b0;
        tick();
        tick();
        chk("c_hread_rvalid", 16'(host_rvalid), 16'h1);
        chk("c_hread_rdata", 16'(host_rdata), 16'h22);
        chk("c_hread_no_spi", 16'(spi_tx_valid), 16'h0);
        tick();

        // 4: second 01 while the slot is full is dropped and sets the sticky flag
        do_reset();
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 8'h40;
        tick();
        chk("o_host_gnt", 16'(host_gnt), 16'h1);
        host_req     = 1'b0;
        spi_rx_data  = {2'b01, 8'h33};
        spi_rx_valid = 1'b1;
        tick();
        spi_rx_data  = {2'b01, 8'h44};
        tick();
        spi_rx_valid = 1'b0;
        chk("o_ovf_set", 16'(spi_ovf), 16'h1);
        chk("o_host_rvalid", 16'(host_rvalid), 16'h1);
        chk("o_host_rdata", 16'(host_rdata), 16'h22);
        tick();
        tick();
        chk("o_first_en", 16'(ram_en), 16'h1);
        chk("o_first_wdata", 16'(ram_wdata), 16'h33);
        chk("o_first_addr", 16'(ram_addr), 16'h00);
        any_en = 1'b0;
        repeat (4) begin
            tick();
            any_en = any_en | ram_en;
        end
        chk("o_second_dropped", 16'(any_en), 16'h0);
        chk("o_ovf_sticky", 16'(spi_ovf), 16'h1);
        rst = 1'b1;
        tick();
        chk("o_ovf_cleared", 16'(spi_ovf), 16'h0);
        rst = 1'b0;

        // 5: reset during RD_WAIT of a host read abandons it
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 8'h40;
        tick();
        chk("x_gnt", 16'(host_gnt), 16'h1);
        host_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("x_no_rvalid_rst", 16'(host_rvalid), 16'h0);
        rst = 1'b0;
        tick();
        chk("x_no_rvalid_after", 16'(host_rvalid), 16'h0);
        chk("x_no_gnt_after", 16'(host_gnt), 16'h0);
        host_req = 1'b1;
        tick();
        chk("x_regrant", 16'(host_gnt), 16'h1);
        host_req = 1'b0;
        n = 0;
        while (!host_rvalid && n < 8) begin
            tick();
            n++;
        end
        chk("x_reread_rvalid", 16'(host_rvalid), 16'h1);
        chk("x_reread_rdata", 16'(host_rdata), 16'h22);
        tick();

        // 6: write address wrap with auto-increment, fixed address without it
        spi_send(2'b00, 8'hFF);
        spi_send(2'b01, 8'h01);
        tick();
        chk("a_first_addr", 16'(ram_addr), 16'hFF);
        chk("a_first_wdata", 16'(ram_wdata), 16'h01);
        spi_send(2'b01, 8'h02);
        tick();
        chk("a_second_en", 16'(ram_en), 16'h1);
        chk("a_second_wdata", 16'(ram_wdata), 16'h02);
`ifdef SPI_RAM_AUTO_INC_EN
        chk("a_second_addr", 16'(ram_addr), 16'h00);
`else
        chk("a_second_addr", 16'(ram_addr), 16'hFF);
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
